// File: rtl/sap_pkg.sv
// Shared constants and state type for the SAP-1.5 program loader.
package sap_pkg;

    localparam int RAM_SIZE_BYTES = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RELEASE,
        S_RUN,
        S_FINISH
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Streams a program into the SAP-1.5 RAM with the CPU held in reset, zero-fills the
// remainder, then releases the CPU and times the run until halt or timeout.
//
// state   | meaning
// IDLE    | waiting for start after reset
// LOAD    | accepting program bytes on the valid/ready stream
// CLEAR   | writing 0x00 to the addresses the program did not cover
// RELEASE | last RAM write settles, CPU still in reset
// RUN     | CPU running, cycle counter active
// FINISH  | halted or timed out; results held until the next start
module program_loader #(
    parameter int RAM_SIZE_BYTES = sap_pkg::RAM_SIZE_BYTES,
    parameter int MAX_CYCLES     = 1000,
    parameter int CYC_WIDTH      = 16,
    localparam int AW            = $clog2(RAM_SIZE_BYTES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [AW:0]          load_len,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [7:0]           ram_wdata,
    output logic                 cpu_reset,
    input  logic                 cpu_halt,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CYC_WIDTH-1:0] cycle_count,
    output logic [7:0]           checksum
);

    import sap_pkg::*;

    localparam logic [AW:0]          FULL  = RAM_SIZE_BYTES[AW:0];
    localparam logic [AW:0]          LAST  = FULL - (AW+1)'(1);
    localparam logic [AW:0]          ONE   = (AW+1)'(1);
    localparam logic [CYC_WIDTH-1:0] MAX_C = CYC_WIDTH'(MAX_CYCLES);

    loader_state_t state, state_next;

    logic [AW:0] ptr;
    logic [AW:0] bytes_left;
    logic [AW:0] len_clamped;

    logic start_go, load_fire, clear_fire, enter_run, run_count, halt_hit, limit_hit;

    assign len_clamped = (load_len > FULL) ? FULL : load_len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        start_go   = 1'b0;
        load_fire  = 1'b0;
        clear_fire = 1'b0;
        enter_run  = 1'b0;
        run_count  = 1'b0;
        halt_hit   = 1'b0;
        limit_hit  = 1'b0;
        case (state)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    start_go   = 1'b1;
                    state_next = (len_clamped != '0) ? S_LOAD : S_CLEAR;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    load_fire = 1'b1;
                    // a full-size image has nothing left to clear
                    if (bytes_left == ONE)
                        state_next = (ptr == LAST) ? S_RELEASE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy       = 1'b1;
                clear_fire = 1'b1;
                if (ptr == LAST) state_next = S_RELEASE;
            end
            S_RELEASE: begin
                busy       = 1'b1;
                enter_run  = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (cpu_halt) begin
                    halt_hit   = 1'b1;
                    state_next = S_FINISH;
                end else if (cycle_count == MAX_C) begin
                    limit_hit  = 1'b1;
                    state_next = S_FINISH;
                end else begin
                    run_count = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            cpu_reset   <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            checksum    <= '0;
            ptr         <= '0;
            bytes_left  <= '0;
        end else begin
            ram_we <= 1'b0;
            if (start_go) begin
                done        <= 1'b0;
                timeout     <= 1'b0;
                cycle_count <= '0;
                checksum    <= '0;
                ptr         <= '0;
                bytes_left  <= len_clamped;
                cpu_reset   <= 1'b1;
            end
            if (load_fire) begin
                ram_we     <= 1'b1;
                ram_addr   <= ptr[AW-1:0];
                ram_wdata  <= s_data;
                checksum   <= checksum + s_data;
                ptr        <= ptr + ONE;
                bytes_left <= bytes_left - ONE;
            end
            if (clear_fire) begin
                ram_we    <= 1'b1;
                ram_addr  <= ptr[AW-1:0];
                ram_wdata <= 8'h00;
                ptr       <= ptr + ONE;
            end
            if (enter_run) cpu_reset <= 1'b0;
            if (run_count) cycle_count <= cycle_count + CYC_WIDTH'(1);
            if (halt_hit)  done <= 1'b1;
            if (limit_hit) begin
                timeout   <= 1'b1;
                cpu_reset <= 1'b1;
            end
        end
    end

endmodule
